// File: rtl/set_tag_lookup_ctrl_if.sv
// Request/response handshake plus block-RAM port bundle for the set tag lookup controller.
// The master side issues requests and plays the RAM; the slave side is the controller.
interface set_tag_lookup_ctrl_if #(
  parameter int TAG_WIDTH             = 9,
  parameter int SET_PTR_WIDTH_IN_BITS = 6,
  parameter int CNT_WIDTH             = 32
);
  localparam int ELEM_W = TAG_WIDTH + 1;

  logic                             req_valid;
  logic                             req_ready;
  logic [SET_PTR_WIDTH_IN_BITS-1:0] req_set;
  logic [TAG_WIDTH-1:0]             req_tag;

  logic                             resp_valid;
  logic                             resp_ready;
  logic                             resp_hit;
  logic [SET_PTR_WIDTH_IN_BITS-1:0] resp_set;
  logic [TAG_WIDTH-1:0]             resp_tag;
  logic                             resp_victim_valid;
  logic [TAG_WIDTH-1:0]             resp_victim_tag;

  logic                             mem_read_en;
  logic [SET_PTR_WIDTH_IN_BITS-1:0] mem_read_set_addr;
  logic [ELEM_W-1:0]                mem_read_element;
  logic                             mem_write_en;
  logic [SET_PTR_WIDTH_IN_BITS-1:0] mem_write_set_addr;
  logic [ELEM_W-1:0]                mem_write_element;
  logic [ELEM_W-1:0]                mem_evict_element;

  logic [CNT_WIDTH-1:0]             hit_count;
  logic [CNT_WIDTH-1:0]             miss_count;

  modport master (
    output req_valid, req_set, req_tag, resp_ready, mem_read_element, mem_evict_element,
    input  req_ready, resp_valid, resp_hit, resp_set, resp_tag, resp_victim_valid,
           resp_victim_tag, mem_read_en, mem_read_set_addr, mem_write_en,
           mem_write_set_addr, mem_write_element, hit_count, miss_count
  );

  modport slave (
    input  req_valid, req_set, req_tag, resp_ready, mem_read_element, mem_evict_element,
    output req_ready, resp_valid, resp_hit, resp_set, resp_tag, resp_victim_valid,
           resp_victim_tag, mem_read_en, mem_read_set_addr, mem_write_en,
           mem_write_set_addr, mem_write_element, hit_count, miss_count
  );
endinterface

// File: rtl/set_tag_lookup_ctrl.sv
// Three-stage tag lookup/replace controller in front of a per-set dual-port RAM.
// Clears every set after reset, then accepts one {set, tag} request per cycle.
module set_tag_lookup_ctrl #(
  parameter int TAG_WIDTH             = 9,
  parameter int NUMBER_SETS           = 64,
  parameter int SET_PTR_WIDTH_IN_BITS = 6,
  parameter int CNT_WIDTH             = 32
) (
  input logic                  clk_in,
  input logic                  reset_in,
  set_tag_lookup_ctrl_if.slave bus
);
  localparam int SET_W  = SET_PTR_WIDTH_IN_BITS;
  localparam int ELEM_W = TAG_WIDTH + 1;
  localparam logic [SET_W-1:0] LAST_SET = SET_W'(NUMBER_SETS - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                state, state_next;
  logic [SET_W-1:0]      init_ptr, init_ptr_next;

  logic                  s1_valid;
  logic [SET_W-1:0]      s1_set;
  logic [TAG_WIDTH-1:0]  s1_tag;
  logic                  s1_fwd;
  logic [ELEM_W-1:0]     s1_fwd_elem;

  logic                  s2_valid;
  logic                  s2_hit;
  logic [SET_W-1:0]      s2_set;
  logic [TAG_WIDTH-1:0]  s2_tag;

  logic [CNT_WIDTH-1:0]  hit_cnt;
  logic [CNT_WIDTH-1:0]  miss_cnt;

  logic                  run;
  logic                  adv_s2;
  logic                  adv_s1;
  logic                  req_ready;
  logic                  accept;
  logic [ELEM_W-1:0]     s1_elem;
  logic                  s1_hit;
  logic                  s1_write;
  logic                  victim_valid;

  assign run       = (state == ST_RUN);
  assign adv_s2    = !s2_valid || bus.resp_ready;
  assign adv_s1    = s1_valid && adv_s2;
  assign req_ready = run && (!s1_valid || adv_s2);
  assign accept    = bus.req_valid && req_ready;
  assign s1_elem   = s1_fwd ? s1_fwd_elem : bus.mem_read_element;
  assign s1_hit    = s1_elem[TAG_WIDTH] && (s1_elem[TAG_WIDTH-1:0] == s1_tag);
  assign s1_write  = run && adv_s1 && !s1_hit;

  // The evict port only changes on a write, and writes need S2 to drain, so it is stable here.
  assign victim_valid          = s2_valid && !s2_hit && bus.mem_evict_element[TAG_WIDTH];
  assign bus.req_ready         = req_ready;
  assign bus.resp_valid        = s2_valid;
  assign bus.resp_hit          = s2_hit;
  assign bus.resp_set          = s2_set;
  assign bus.resp_tag          = s2_tag;
  assign bus.resp_victim_valid = victim_valid;
  assign bus.resp_victim_tag   = victim_valid ? bus.mem_evict_element[TAG_WIDTH-1:0] : '0;
  assign bus.hit_count         = hit_cnt;
  assign bus.miss_count        = miss_cnt;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state    <= ST_INIT;
      init_ptr <= '0;
    end else begin
      state    <= state_next;
      init_ptr <= init_ptr_next;
    end
  end

  // RAM ports are held quiet while reset is asserted so the clear sweep starts cleanly.
  always_comb begin
    state_next             = state;
    init_ptr_next          = init_ptr;
    bus.mem_read_en        = 1'b0;
    bus.mem_read_set_addr  = '0;
    bus.mem_write_en       = 1'b0;
    bus.mem_write_set_addr = '0;
    bus.mem_write_element  = '0;
    if (!reset_in) begin
      unique case (state)
        ST_INIT: begin
          bus.mem_read_en        = 1'b1;
          bus.mem_read_set_addr  = init_ptr;
          bus.mem_write_en       = 1'b1;
          bus.mem_write_set_addr = init_ptr;
          init_ptr_next          = init_ptr + SET_W'(1);
          if (init_ptr == LAST_SET) begin
            state_next = ST_RUN;
          end
        end
        ST_RUN: begin
          if (s1_write) begin
            bus.mem_read_en        = 1'b1;
            bus.mem_read_set_addr  = s1_set;
            bus.mem_write_en       = 1'b1;
            bus.mem_write_set_addr = s1_set;
            bus.mem_write_element  = {1'b1, s1_tag};
          end
          if (accept) begin
            bus.mem_read_en       = 1'b1;
            bus.mem_read_set_addr = bus.req_set;
          end
        end
        default: state_next = ST_INIT;
      endcase
    end
  end

  // A same-set request accepted while S1 writes would read the stale pre-write value, so forward.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      s1_valid    <= 1'b0;
      s1_set      <= '0;
      s1_tag      <= '0;
      s1_fwd      <= 1'b0;
      s1_fwd_elem <= '0;
      s2_valid    <= 1'b0;
      s2_hit      <= 1'b0;
      s2_set      <= '0;
      s2_tag      <= '0;
    end else begin
      if (adv_s2) begin
        s2_valid <= adv_s1;
        if (adv_s1) begin
          s2_hit <= s1_hit;
          s2_set <= s1_set;
          s2_tag <= s1_tag;
        end
      end
      if (accept) begin
        s1_valid    <= 1'b1;
        s1_set      <= bus.req_set;
        s1_tag      <= bus.req_tag;
        s1_fwd      <= s1_write && (bus.req_set == s1_set);
        s1_fwd_elem <= {1'b1, s1_tag};
      end else if (adv_s1) begin
        s1_valid <= 1'b0;
        s1_fwd   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (run && adv_s1) begin
      if (s1_hit) begin
        if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_WIDTH'(1);
      end else begin
        if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_WIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_set_tag_lookup_ctrl.sv
// Directed bench for set_tag_lookup_ctrl: behavioural RAM, reference tag array and a
// response scoreboard filled on request acceptance and drained on response handshakes.
module tb_set_tag_lookup_ctrl;
  localparam int TAG_W  = 9;
  localparam int SETS   = 64;
  localparam int SET_W  = 6;
  localparam int CNT_W  = 32;
  localparam int ELEM_W = TAG_W + 1;

  typedef struct packed {
    logic             hit;
    logic [SET_W-1:0] set;
    logic [TAG_W-1:0] tag;
    logic             vvalid;
    logic [TAG_W-1:0] vtag;
  } resp_t;

  logic clk_in   = 1'b0;
  logic reset_in = 1'b1;

  int checks      = 0;
  int errors      = 0;
  int write_count = 0;
  int exp_hits    = 0;
  int exp_misses  = 0;

  resp_t             exp_q[$];
  resp_t             mon_e;
  logic [ELEM_W-1:0] old_elem;
  logic [ELEM_W-1:0] model [SETS];
  logic [ELEM_W-1:0] ram [SETS] = '{default: 10'h3FF};

  always #5 clk_in = ~clk_in;

  set_tag_lookup_ctrl_if #(
    .TAG_WIDTH(TAG_W), .SET_PTR_WIDTH_IN_BITS(SET_W), .CNT_WIDTH(CNT_W)
  ) bus ();

  set_tag_lookup_ctrl #(
    .TAG_WIDTH(TAG_W), .NUMBER_SETS(SETS), .SET_PTR_WIDTH_IN_BITS(SET_W), .CNT_WIDTH(CNT_W)
  ) dut (
    .clk_in(clk_in),
    .reset_in(reset_in),
    .bus(bus)
  );

  // Dual-port RAM: 1-cycle read, evict port captures the pre-write content of the write address.
  always @(posedge clk_in) begin
    if (bus.mem_read_en) begin
      bus.mem_read_element <= ram[bus.mem_read_set_addr];
      if (bus.mem_write_en) begin
        bus.mem_evict_element        <= ram[bus.mem_write_set_addr];
        ram[bus.mem_write_set_addr]  <= bus.mem_write_element;
        write_count                  <= write_count + 1;
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Scoreboard: pop on response handshake, predict with the reference array on acceptance.
  always @(negedge clk_in) begin
    if (!reset_in) begin
      if (bus.resp_valid && bus.resp_ready) begin
        if (exp_q.size() == 0) begin
          check_output("resp_unexpected_qsize", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_e = exp_q.pop_front();
          check_output("resp_hit",    32'(bus.resp_hit),          32'(mon_e.hit));
          check_output("resp_set",    32'(bus.resp_set),          32'(mon_e.set));
          check_output("resp_tag",    32'(bus.resp_tag),          32'(mon_e.tag));
          check_output("resp_vvalid", 32'(bus.resp_victim_valid), 32'(mon_e.vvalid));
          check_output("resp_vtag",   32'(bus.resp_victim_tag),   32'(mon_e.vtag));
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        old_elem   = model[bus.req_set];
        mon_e.set  = bus.req_set;
        mon_e.tag  = bus.req_tag;
        mon_e.hit  = old_elem[TAG_W] && (old_elem[TAG_W-1:0] == bus.req_tag);
        if (mon_e.hit) begin
          mon_e.vvalid = 1'b0;
          mon_e.vtag   = '0;
          exp_hits++;
        end else begin
          mon_e.vvalid        = old_elem[TAG_W];
          mon_e.vtag          = old_elem[TAG_W] ? old_elem[TAG_W-1:0] : '0;
          model[bus.req_set]  = {1'b1, bus.req_tag};
          exp_misses++;
        end
        exp_q.push_back(mon_e);
      end
    end
  end

  task automatic apply_stimulus(input logic [SET_W-1:0] set, input logic [TAG_W-1:0] tag);
    int waited = 0;
    bus.req_valid = 1'b1;
    bus.req_set   = set;
    bus.req_tag   = tag;
    @(negedge clk_in);
    while (!bus.req_ready && waited < 100) begin
      @(negedge clk_in);
      waited++;
    end
    check_output("req_accepted", 32'(bus.req_ready), 32'd1);
    @(posedge clk_in);
    #1;
  endtask

  task automatic drain();
    int cycles = 0;
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk_in);
    while ((exp_q.size() != 0 || bus.resp_valid) && cycles < 100) begin
      @(negedge clk_in);
      cycles++;
    end
    check_output("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    check_output("drain_resp_idle",   32'(bus.resp_valid), 32'd0);
    @(posedge clk_in);
    #1;
  endtask

  // Expects to be entered just after reset release; follows the clear sweep into RUN.
  task automatic init_check();
    for (int i = 0; i < SETS; i++) begin
      @(negedge clk_in);
      check_output($sformatf("init_cycle_%0d", i),
                   {14'd0, bus.req_ready, bus.mem_read_en, bus.mem_write_en,
                    bus.mem_write_set_addr, bus.mem_write_element},
                   {14'd0, 1'b0, 1'b1, 1'b1, 6'(i), 10'd0});
    end
    @(negedge clk_in);
    check_output("init_done_ready", 32'(bus.req_ready),    32'd1);
    check_output("init_done_nowr",  32'(bus.mem_write_en), 32'd0);
    @(posedge clk_in);
    #1;
  endtask

  int                   wc;
  int                   idx;
  logic                 snap_valid;
  logic                 acc;
  logic [31:0]          snap;
  logic [31:0]          fields;
  logic [SET_W-1:0]     stall_set [3] = '{6'd7, 6'd8, 6'd9};
  logic [TAG_W-1:0]     stall_tag [3] = '{9'h010, 9'h011, 9'h012};

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_set    = '0;
    bus.req_tag    = '0;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < SETS; i++) model[i] = '0;

    reset_in = 1'b1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check_output("rst_req_ready",  32'(bus.req_ready),    32'd0);
    check_output("rst_resp_valid", 32'(bus.resp_valid),   32'd0);
    check_output("rst_mem_rd",     32'(bus.mem_read_en),  32'd0);
    check_output("rst_mem_wr",     32'(bus.mem_write_en), 32'd0);
    check_output("rst_hits",       bus.hit_count,         32'd0);
    check_output("rst_misses",     bus.miss_count,        32'd0);
    @(posedge clk_in);
    #1;
    reset_in = 1'b0;
    init_check();

    // Cold miss then repeat hit, with the 2-cycle accept-to-response latency.
    wc = write_count;
    apply_stimulus(6'd5, 9'h1A2);
    bus.req_valid = 1'b0;
    @(negedge clk_in);
    check_output("latency_cycle1", 32'(bus.resp_valid), 32'd0);
    @(negedge clk_in);
    check_output("latency_cycle2", 32'(bus.resp_valid), 32'd1);
    drain();
    check_output("cold_miss_writes", 32'(write_count - wc), 32'd1);
    check_output("cold_miss_ram5",   32'(ram[5]),           32'h3A2);
    wc = write_count;
    apply_stimulus(6'd5, 9'h1A2);
    drain();
    check_output("repeat_hit_writes", 32'(write_count - wc), 32'd0);

    // Same-set back-to-back: replace then hit via forward.
    apply_stimulus(6'd5, 9'h1A2);
    apply_stimulus(6'd5, 9'h033);
    apply_stimulus(6'd5, 9'h033);
    drain();
    check_output("replace_ram5", 32'(ram[5]), 32'h233);

    wc = write_count;
    apply_stimulus(6'd5, 9'h0AA);
    apply_stimulus(6'd5, 9'h0AA);
    drain();
    check_output("fwd_single_write", 32'(write_count - wc), 32'd1);

    // Consumer stall with three requests offered.
    wc             = write_count;
    bus.resp_ready = 1'b0;
    idx            = 0;
    snap_valid     = 1'b0;
    snap           = '0;
    bus.req_valid  = 1'b1;
    bus.req_set    = stall_set[0];
    bus.req_tag    = stall_tag[0];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_in);
      acc    = bus.req_valid && bus.req_ready;
      fields = {5'd0, bus.resp_valid, bus.resp_hit, bus.resp_set, bus.resp_tag,
                bus.resp_victim_valid, bus.resp_victim_tag};
      if (bus.resp_valid) begin
        if (!snap_valid) begin
          snap       = fields;
          snap_valid = 1'b1;
          wc         = write_count;
        end else begin
          check_output($sformatf("stall_stable_%0d", c), fields, snap);
        end
      end
      @(posedge clk_in);
      #1;
      if (acc) begin
        idx++;
        if (idx < 3) begin
          bus.req_set = stall_set[idx];
          bus.req_tag = stall_tag[idx];
        end else begin
          bus.req_valid = 1'b0;
        end
      end
    end
    check_output("stall_seen_resp",  32'(snap_valid),        32'd1);
    check_output("stall_no_writes",  32'(write_count - wc),  32'd0);
    check_output("stall_ready_low",  32'(bus.req_ready),     32'd0);
    check_output("stall_accepted",   32'(idx),               32'd2);
    bus.resp_ready = 1'b1;
    apply_stimulus(stall_set[2], stall_tag[2]);
    drain();
    check_output("count_hits",   bus.hit_count,  32'(exp_hits));
    check_output("count_misses", bus.miss_count, 32'(exp_misses));

    // Reset with S1 and S2 occupied.
    bus.resp_ready = 1'b0;
    apply_stimulus(6'd10, 9'h001);
    apply_stimulus(6'd11, 9'h002);
    bus.req_valid = 1'b0;
    #1;
    reset_in = 1'b1;
    #1;
    check_output("midrst_resp_valid", 32'(bus.resp_valid),   32'd0);
    check_output("midrst_hits",       bus.hit_count,         32'd0);
    check_output("midrst_misses",     bus.miss_count,        32'd0);
    check_output("midrst_ready",      32'(bus.req_ready),    32'd0);
    check_output("midrst_mem_wr",     32'(bus.mem_write_en), 32'd0);
    exp_q.delete();
    for (int i = 0; i < SETS; i++) model[i] = '0;
    exp_hits   = 0;
    exp_misses = 0;
    @(posedge clk_in);
    #1;
    reset_in       = 1'b0;
    bus.resp_ready = 1'b1;
    init_check();
    apply_stimulus(6'd5, 9'h1A2);
    drain();
    check_output("post_rst_misses", bus.miss_count, 32'(exp_misses));
    check_output("post_rst_hits",   bus.hit_count,  32'(exp_hits));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
